pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Combines three inputs into one consistent set of per-stage freeze, flush and bubble controls:
  - the hazard detection result from ID;
  - branch resolution from EXE;
  - multi-cycle SRAM handshakes from MEM.
- Owns the SRAM wait state machine, a wait timeout, and saturating performance counters.
- Sits beside the hazard unit; drives the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before ERROR (1..255).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hazard_detected  in  1  from hazard detection unit (ID stage)
- branch_taken  in  1  EXE-stage branch/jump taken
- mem_r_en  in  1  MEM-stage load
- mem_w_en  in  1  MEM-stage store
- sram_ready  in  1  SRAM controller access-complete, single-cycle pulse
- cnt_clr  in  1  synchronous clear of performance counters
- freeze_pc  out  1  hold PC
- freeze_if_id  out  1  hold IF/ID register
- bubble_id_ex  out  1  load NOP into ID/EX
- flush_if_id  out  1  load NOP into IF/ID
- freeze_all  out  1  hold PC and every pipeline register (memory wait)
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  cycles with a hazard stall applied
- flush_cnt  out  CNT_W  taken-branch flushes applied
- mem_wait_cnt  out  CNT_W  cycles with freeze_all asserted

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high.
  - Next edge with rst=1: state=RUN, wait_cnt=0, mem_timeout=0, all counters=0.
  - While rst=1, every control output is forced to 0.
- mem_access = mem_r_en | mem_w_en.
- States: RUN, MEM_WAIT, ERROR.
- RUN:
  - mem_access & !sram_ready -> MEM_WAIT, wait_cnt=1.
  - Otherwise stay in RUN.
  - A same-cycle sram_ready completes the access with no freeze.
- MEM_WAIT:
  - sram_ready -> RUN, wait_cnt=0.
  - Else if wait_cnt==MEM_TIMEOUT -> ERROR.
  - Else wait_cnt+1.
  - mem_access is ignored in this state; MEM is frozen, so the request is stable.
- ERROR:
  - mem_timeout=1 and freeze_all=1 every cycle.
  - Left only by rst.
- freeze_all (combinational, same cycle):
  - RUN: mem_access & !sram_ready.
  - MEM_WAIT: !sram_ready.
  - ERROR: 1.
  - The sram_ready cycle itself is not frozen.
- Priority, highest first: rst > freeze_all > branch_taken > hazard_detected.
- When freeze_all=1:
  - freeze_pc=1 and freeze_if_id=1.
  - bubble_id_ex=0 and flush_if_id=0.
  - branch_taken is held by the frozen EX/MEM path and acts on the first unfrozen cycle.
- When freeze_all=0 and branch_taken=1:
  - flush_if_id=1 and bubble_id_ex=1.
  - freeze_pc=0, so the PC loads the branch target.
  - Any concurrent hazard_detected is ignored, because the ID instruction is squashed.
- When freeze_all=0, branch_taken=0 and hazard_detected=1:
  - freeze_pc=1, freeze_if_id=1, bubble_id_ex=1, flush_if_id=0.
- Otherwise all control outputs are 0.
- Latency: all control outputs are combinational from inputs plus registered state; zero-cycle.
- Counters:
  - Each is an independent saturating counter that holds at 2^CNT_W-1.
  - stall_cnt increments on the hazard-stall case.
  - flush_cnt increments on the branch case.
  - mem_wait_cnt increments when freeze_all=1.
  - cnt_clr zeroes all three. It takes priority over increment in the same cycle and does not affect state or mem_timeout.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - default MEM_TIMEOUT;
  - NOP instruction constant shared with the pipeline registers.
- One sub-module, sat_counter (param W; ports clk, rst, clr, inc, count), instantiated three times.

Test Plan:
- hazard_detected=1 for 2 cycles, no memory access -> freeze_pc=freeze_if_id=bubble_id_ex=1 both cycles; stall_cnt=2, flush_cnt=0.
- branch_taken=1 and hazard_detected=1 in the same cycle -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0; flush_cnt=1, stall_cnt=0.
- mem_r_en=1 with sram_ready arriving on the 4th cycle -> freeze_all=1 for 3 cycles then 0; state RUN→MEM_WAIT→RUN; mem_wait_cnt=3.
- mem_w_en=1 with sram_ready asserted in the same first cycle -> freeze_all never asserted; state stays RUN.
- branch_taken=1 during a 3-cycle SRAM wait -> no flush while frozen; flush_if_id=1 exactly on the sram_ready cycle.
- MEM_TIMEOUT=4, sram_ready never asserted -> ERROR after 4 wait cycles, mem_timeout=1 and freeze_all=1 held; rst=1 for one cycle -> state RUN, all counters 0, mem_timeout=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller and the
// pipeline registers it drives.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam int DEFAULT_MEM_TIMEOUT = 15;
    localparam int WAIT_CNT_W          = 8;

    // Instruction word the pipeline registers load when a bubble or flush is applied.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments; combinational logic uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Central stall/flush sequencer: merges ID hazards, EXE branches and MEM SRAM
// waits into per-stage freeze/flush/bubble controls, with timeout and counters.
module pipeline_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             sram_ready,
    input  logic             cnt_clr,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT = WAIT_CNT_W'(MEM_TIMEOUT);

    state_e                  state_q;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic                    mem_timeout_q;

    logic mem_access;
    logic mem_freeze;
    logic stall_inc;
    logic flush_inc;

    assign mem_access = mem_r_en | mem_w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_access && !sram_ready) begin
                        state_q    <= ST_MEM_WAIT;
                        wait_cnt_q <= WAIT_CNT_W'(1);
                    end
                end
                // The MEM request is held stable by the freeze, so only sram_ready matters here.
                ST_MEM_WAIT: begin
                    if (sram_ready) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == TIMEOUT) begin
                        state_q       <= ST_ERROR;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
                    end
                end
                ST_ERROR: begin
                    mem_timeout_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        mem_freeze = 1'b0;
        case (state_q)
            ST_RUN:      mem_freeze = mem_access & ~sram_ready;
            ST_MEM_WAIT: mem_freeze = ~sram_ready;
            ST_ERROR:    mem_freeze = 1'b1;
            default:     mem_freeze = 1'b0;
        endcase
    end

    // A branch seen while frozen is held upstream and acts on the first unfrozen cycle.
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        freeze_all   = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (rst) begin
            freeze_all = 1'b0;
        end else if (mem_freeze) begin
            freeze_all   = 1'b1;
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
        end else if (branch_taken) begin
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            flush_inc    = 1'b1;
        end else if (hazard_detected) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            bubble_id_ex = 1'b1;
            stall_inc    = 1'b1;
        end
    end

    assign mem_timeout = mem_timeout_q & ~rst;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (freeze_all),
        .count (mem_wait_cnt)
    );

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: expected controls are queued as each
// cycle is driven and compared once the outputs settle; counters checked per scenario.
module tb_pipeline_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_detected = 1'b0;
    logic branch_taken = 1'b0;
    logic mem_r_en = 1'b0;
    logic mem_w_en = 1'b0;
    logic sram_ready = 1'b0;
    logic cnt_clr = 1'b0;

    logic        freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_all, mem_timeout;
    logic [31:0] stall_cnt, flush_cnt, mem_wait_cnt;

    logic        s_freeze_pc, s_freeze_if_id, s_bubble_id_ex, s_flush_if_id, s_freeze_all, s_mem_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_mem_wait_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    localparam logic [5:0] C_IDLE   = 6'b000000;
    localparam logic [5:0] C_STALL  = 6'b111000;
    localparam logic [5:0] C_FLUSH  = 6'b001100;
    localparam logic [5:0] C_FROZEN = 6'b110010;
    localparam logic [5:0] C_ERROR  = 6'b110011;

    always #5 clk = ~clk;

    pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_r_en        (mem_r_en),
        .mem_w_en        (mem_w_en),
        .sram_ready      (sram_ready),
        .cnt_clr         (cnt_clr),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .flush_if_id     (flush_if_id),
        .freeze_all      (freeze_all),
        .mem_timeout     (mem_timeout),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_wait_cnt    (mem_wait_cnt)
    );

    pipeline_controller #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_small (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_r_en        (mem_r_en),
        .mem_w_en        (mem_w_en),
        .sram_ready      (sram_ready),
        .cnt_clr         (cnt_clr),
        .freeze_pc       (s_freeze_pc),
        .freeze_if_id    (s_freeze_if_id),
        .bubble_id_ex    (s_bubble_id_ex),
        .flush_if_id     (s_flush_if_id),
        .freeze_all      (s_freeze_all),
        .mem_timeout     (s_mem_timeout),
        .stall_cnt       (s_stall_cnt),
        .flush_cnt       (s_flush_cnt),
        .mem_wait_cnt    (s_mem_wait_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle of stimulus; expected controls are {fpc, fifid, bub, flush, fall, tmo}.
    task automatic drive(input string tag, input logic r, input logic h, input logic b,
                         input logic rd, input logic wr, input logic rdy, input logic clr,
                         input logic [5:0] exp);
        logic [5:0] e;
        string      t;
        @(negedge clk);
        rst = r; hazard_detected = h; branch_taken = b;
        mem_r_en = rd; mem_w_en = wr; sram_ready = rdy; cnt_clr = clr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {58'd0, freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_all, mem_timeout},
              {58'd0, e});
    endtask

    // Counters reflect every cycle driven so far; inputs go idle afterwards.
    task automatic check_cnts(input string tag, input int s, input int f, input int m);
        @(negedge clk);
        check({tag, "_stall"}, 64'(stall_cnt), 64'(s));
        check({tag, "_flush"}, 64'(flush_cnt), 64'(f));
        check({tag, "_mwait"}, 64'(mem_wait_cnt), 64'(m));
        check({tag, "_stall_sat"}, 64'(s_stall_cnt), 64'((s > 3) ? 3 : s));
        check({tag, "_mwait_sat"}, 64'(s_mem_wait_cnt), 64'((m > 3) ? 3 : m));
        rst = 1'b0; hazard_detected = 1'b0; branch_taken = 1'b0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; sram_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_cnts();
        drive("clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE);
    endtask

    initial begin
        // Reset: controls forced low even with every request active.
        drive("rst_ctrl0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE);
        drive("rst_ctrl1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE);
        check_cnts("rst", 0, 0, 0);

        // Two-cycle hazard stall.
        drive("haz0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL);
        drive("haz1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL);
        check_cnts("haz", 2, 0, 0);
        clear_cnts();

        // Branch overrides a concurrent hazard.
        drive("br_haz", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_FLUSH);
        check_cnts("br", 0, 1, 0);
        clear_cnts();

        // Load with sram_ready on the 4th cycle.
        drive("ld_w0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        drive("ld_w1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        drive("ld_w2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        drive("ld_rdy", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_IDLE);
        drive("ld_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
        check_cnts("ld", 0, 0, 3);
        clear_cnts();

        // Store completing in its first cycle never freezes.
        drive("st_rdy", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_IDLE);
        drive("st_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
        drive("st_haz", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL);
        check_cnts("st", 1, 0, 0);
        clear_cnts();

        // Branch held across a 3-cycle wait flushes only on the ready cycle.
        drive("brw0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        drive("brw1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        drive("brw2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        drive("brw_rdy", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, C_FLUSH);
        check_cnts("brw", 0, 1, 3);
        clear_cnts();

        // Saturation on the 2-bit instance and clear-over-increment.
        for (int i = 0; i < 5; i++) begin
            drive($sformatf("sat%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL);
        end
        check_cnts("sat", 5, 0, 0);
        drive("clr_inc", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_STALL);
        check_cnts("clr_inc", 0, 0, 0);

        // Timeout: RUN cycle plus 4 MEM_WAIT cycles, then ERROR is sticky.
        for (int i = 0; i < 5; i++) begin
            drive($sformatf("to_w%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_FROZEN);
        end
        drive("to_err0", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_ERROR);
        drive("to_err_rdy", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_ERROR);
        check_cnts("to", 0, 0, 7);
        drive("to_err_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ERROR);
        drive("to_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE);
        check_cnts("to_rst", 0, 0, 0);
        drive("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE);
        drive("post_rst_haz", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_STALL);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
